// File: rtl/pipe_spawn_ctrl.sv
// Paces pipe spawn requests during a game and picks a non-repeating gap position.
// Holds each request until acknowledged; game_on low aborts to IDLE.
module pipe_spawn_ctrl #(
  parameter int FIRST_DELAY  = 8,
  parameter int SPAWN_PERIOD = 16,
  parameter int GAP_MAX      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_on,
  input  logic       tick,
  input  logic [2:0] rnd,
  input  logic       spawn_ack,
  output logic       lfsr_active,
  output logic       spawn_req,
  output logic [2:0] gap_pos,
  output logic [7:0] pipes_spawned
);

  localparam int MAXP = (FIRST_DELAY > SPAWN_PERIOD) ? FIRST_DELAY : SPAWN_PERIOD;
  localparam int CW   = $clog2(MAXP + 1);
  localparam logic [CW-1:0] FD  = CW'(FIRST_DELAY);
  localparam logic [CW-1:0] SP  = CW'(SPAWN_PERIOD);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [2:0]    GM  = 3'(GAP_MAX);

  typedef enum logic [1:0] {IDLE, COUNT, REQUEST} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, limit, limit_nx;
  logic [2:0]    prev_gap, prev_gap_nx, gap_nx, g_clamp, g_pick;
  logic          spawn_req_nx;
  logic [7:0]    pipes_nx;

  // Clamp the random value, then step past a repeat of the previous gap.
  always_comb begin
    g_clamp = (rnd > GM) ? GM : rnd;
    g_pick  = g_clamp;
    if (g_clamp == prev_gap) begin
      g_pick = (g_clamp == GM) ? 3'd0 : g_clamp + 3'd1;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    limit_nx     = limit;
    prev_gap_nx  = prev_gap;
    gap_nx       = gap_pos;
    spawn_req_nx = spawn_req;
    pipes_nx     = pipes_spawned;
    if (!game_on) begin
      state_nx     = IDLE;
      spawn_req_nx = 1'b0;
      cnt_nx       = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx     = COUNT;
          cnt_nx       = '0;
          limit_nx     = FD;
          pipes_nx     = 8'd0;
          prev_gap_nx  = 3'd0;
          spawn_req_nx = 1'b0;
        end
        COUNT: begin
          if (tick) begin
            cnt_nx = cnt + ONE;
            if (cnt == limit - ONE) begin
              state_nx     = REQUEST;
              spawn_req_nx = 1'b1;
              gap_nx       = g_pick;
              prev_gap_nx  = g_pick;
            end
          end
        end
        REQUEST: begin
          if (spawn_ack) begin
            state_nx     = COUNT;
            spawn_req_nx = 1'b0;
            cnt_nx       = '0;
            limit_nx     = SP;
            if (pipes_spawned != 8'hFF) pipes_nx = pipes_spawned + 8'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      limit         <= FD;
      prev_gap      <= 3'd0;
      gap_pos       <= 3'd0;
      spawn_req     <= 1'b0;
      pipes_spawned <= 8'd0;
      lfsr_active   <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      limit         <= limit_nx;
      prev_gap      <= prev_gap_nx;
      gap_pos       <= gap_nx;
      spawn_req     <= spawn_req_nx;
      pipes_spawned <= pipes_nx;
      lfsr_active   <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_pipe_spawn_ctrl.sv
// Directed plus randomized bench for pipe_spawn_ctrl against a countdown reference model.
module tb_pipe_spawn_ctrl;
  localparam int FD = 8;
  localparam int SP = 16;
  localparam int GM = 5;

  logic       clk = 1'b0;
  logic       reset, game_on, tick, spawn_ack;
  logic [2:0] rnd;
  logic       lfsr_active, spawn_req;
  logic [2:0] gap_pos;
  logic [7:0] pipes_spawned;

  logic       tick_s, ack_s;
  logic [2:0] rnd_s;
  logic       s_lfsr, s_req;
  logic [2:0] s_gap;
  logic [7:0] s_pipes;

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";

  // Reference model: ticks remaining until the next request
  bit m_run, m_wait, m_req, m_lfsr;
  int m_left, m_gap, m_prev, m_cnt;

  pipe_spawn_ctrl #(.FIRST_DELAY(FD), .SPAWN_PERIOD(SP), .GAP_MAX(GM)) u_dut (
    .clk(clk), .reset(reset), .game_on(game_on), .tick(tick), .rnd(rnd),
    .spawn_ack(spawn_ack), .lfsr_active(lfsr_active), .spawn_req(spawn_req),
    .gap_pos(gap_pos), .pipes_spawned(pipes_spawned)
  );

  pipe_spawn_ctrl #(.FIRST_DELAY(FD), .SPAWN_PERIOD(1), .GAP_MAX(GM)) u_sat (
    .clk(clk), .reset(reset), .game_on(game_on), .tick(tick_s), .rnd(rnd_s),
    .spawn_ack(ack_s), .lfsr_active(s_lfsr), .spawn_req(s_req),
    .gap_pos(s_gap), .pipes_spawned(s_pipes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic g, input logic t,
                            input logic [2:0] rn, input logic a);
    int c;
    if (r) begin
      m_run = 0; m_wait = 0; m_req = 0; m_lfsr = 0;
      m_gap = 0; m_cnt = 0; m_prev = 0;
    end else if (!g) begin
      m_run = 0; m_wait = 0; m_req = 0; m_lfsr = 0;
    end else if (!m_run) begin
      m_run = 1; m_lfsr = 1; m_left = FD; m_cnt = 0; m_prev = 0; m_req = 0;
    end else if (m_wait) begin
      if (a) begin
        m_wait = 0; m_req = 0; m_left = SP;
        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
    end else if (t) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        c = (int'(rn) > GM) ? GM : int'(rn);
        if (c == m_prev) c = (c == GM) ? 0 : c + 1;
        m_gap = c; m_prev = c; m_wait = 1; m_req = 1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic g, input logic t,
                     input logic [2:0] rn, input logic a);
    reset = r; game_on = g; tick = t; rnd = rn; spawn_ack = a;
    model_step(r, g, t, rn, a);
    @(posedge clk);
    #1;
    chk("spawn_req", {7'd0, spawn_req}, 8'(m_req));
    chk("lfsr_active", {7'd0, lfsr_active}, 8'(m_lfsr));
    chk("gap_pos", {5'd0, gap_pos}, 8'(m_gap));
    chk("pipes_spawned", pipes_spawned, 8'(m_cnt));
  endtask

  // Acknowledge the pending request, run one full period, sample rn on the last tick
  task automatic spawn(input logic [2:0] rn, input logic [2:0] expg, input string tag);
    cyc(0, 1, 0, 3'($urandom), 1);
    for (int i = 0; i < SP - 1; i++) cyc(0, 1, 1, 3'($urandom), 0);
    chk({tag, "_pre"}, {7'd0, spawn_req}, 8'd0);
    cyc(0, 1, 1, rn, 0);
    chk({tag, "_req"}, {7'd0, spawn_req}, 8'd1);
    chk({tag, "_gap"}, {5'd0, gap_pos}, {5'd0, expg});
  endtask

  initial begin
    int w;
    int exp_p;
    reset = 1; game_on = 0; tick = 0; rnd = 0; spawn_ack = 0;
    tick_s = 0; ack_s = 0; rnd_s = 0;
    m_run = 0; m_wait = 0; m_req = 0; m_lfsr = 0;
    m_left = 0; m_gap = 0; m_prev = 0; m_cnt = 0;

    phase = "reset";
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    phase = "start";
    cyc(0, 1, 0, 0, 0);
    chk("lfsr_on", {7'd0, lfsr_active}, 8'd1);
    for (int i = 0; i < FD - 1; i++) cyc(0, 1, 1, 3'($urandom), 0);
    chk("no_req_7", {7'd0, spawn_req}, 8'd0);
    cyc(0, 1, 1, 3'd3, 0);
    chk("first_req", {7'd0, spawn_req}, 8'd1);
    chk("first_gap", {5'd0, gap_pos}, 8'd3);

    phase = "hold";
    for (int i = 0; i < 20; i++) cyc(0, 1, (i % 4) == 0, 3'($urandom), 0);
    chk("hold_req", {7'd0, spawn_req}, 8'd1);
    chk("hold_gap", {5'd0, gap_pos}, 8'd3);
    spawn(3'd3, 3'd4, "repeat");
    chk("one_pipe", pipes_spawned, 8'd1);
    spawn(3'd5, 3'd5, "top");
    spawn(3'd6, 3'd0, "wrap");
    spawn(3'd2, 3'd2, "mid");
    spawn(3'd6, 3'd5, "clamp");

    phase = "random";
    for (int i = 0; i < 800; i++)
      cyc(($urandom % 100) == 0, ($urandom % 50) != 0, 1'($urandom), 3'($urandom),
          ($urandom % 3) == 0);

    phase = "abort";
    cyc(0, 1, 0, 0, 1);
    w = 0;
    while (!spawn_req && w < 40) begin
      cyc(0, 1, 1, 3'($urandom), 0);
      w++;
    end
    chk("abort_wait", {7'd0, spawn_req}, 8'd1);
    exp_p = m_cnt;
    cyc(0, 0, 1, 3'($urandom), 1);
    chk("abort_req", {7'd0, spawn_req}, 8'd0);
    chk("abort_lfsr", {7'd0, lfsr_active}, 8'd0);
    chk("abort_pipes", pipes_spawned, 8'(exp_p));

    phase = "rst_mid";
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 3'($urandom), 0);
    cyc(1, 1, 1, 3'($urandom), 0);
    chk("rc_lfsr", {7'd0, lfsr_active}, 8'd0);
    chk("rc_pipes", pipes_spawned, 8'd0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < FD - 1; i++) cyc(0, 1, 1, 3'($urandom), 0);
    chk("rc_no_req", {7'd0, spawn_req}, 8'd0);
    cyc(0, 1, 1, 3'($urandom), 0);
    chk("rc_req", {7'd0, spawn_req}, 8'd1);
    cyc(1, 1, 0, 0, 1);
    chk("rr_req", {7'd0, spawn_req}, 8'd0);
    chk("rr_gap", {5'd0, gap_pos}, 8'd0);
    chk("rr_pipes", pipes_spawned, 8'd0);

    phase = "sat";
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    tick_s = 1;
    for (int k = 0; k < 300; k++) begin
      w = 0;
      while (!s_req && w < 12) begin
        rnd_s = 3'($urandom);
        cyc(0, 1, 0, 0, 0);
        w++;
      end
      chk("sat_req", {7'd0, s_req}, 8'd1);
      ack_s = 1;
      cyc(0, 1, 0, 0, 0);
      ack_s = 0;
      chk("sat_pipes", s_pipes, (k + 1 > 255) ? 8'd255 : 8'(k + 1));
      chk("sat_drop", {7'd0, s_req}, 8'd0);
    end
    tick_s = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
